world_view_sequencer: RTL and testbench

- Sequences the world-to-camera vertex transform for one frame using a single shared signed multiplier and accumulator.
- Each vertex is read from triangle memory, translated by the camera position, projected onto the camera i/j/k basis (Q.10 fixed point, 1024 = 1.0), and written to camera-space memory.
- Sits between the maze geometry store and the rasteriser front end. Software or the top-level FSM pulses start once per frame.

---
 rtl/world_pkg.sv | 27 ++
 rtl/dot3_mac.sv | 56 +++++
 rtl/world_view_sequencer.sv | 213 +++++++++++++++++++++
 tb/tb_world_view_sequencer.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/world_pkg.sv
// Shared constants, vector type and sequencer state encoding for the world-to-camera transform.
package world_pkg;

    // Component / axis indices within a {Z,Y,X} packed vector
    localparam int unsigned X = 0;
    localparam int unsigned Y = 1;
    localparam int unsigned Z = 2;

    // Fraction bits of the Q.10 camera basis (1024 = 1.0)
    localparam int unsigned FRAC = 10;

    localparam int unsigned MAX_TRIANGLES = 64;
    localparam int unsigned TRI_AW        = 6;

    // Three signed 32-bit components, index X/Y/Z
    typedef logic signed [2:0][31:0] vec3;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StLatch,
        StMac,
        StWrite,
        StDone
    } seq_state_e;

endpackage

// File: rtl/dot3_mac.sv
// Shared signed multiply-accumulate for one basis projection, with Q.10 rescale and int32 clamp.
module dot3_mac
    import world_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               clr,
    input  logic               en,
    input  logic signed [32:0] a,
    input  logic signed [31:0] b,
    output logic signed [31:0] result,
    output logic               sat
);

    logic signed [64:0] prod;
    logic signed [66:0] acc_q;
    logic signed [66:0] acc_d;
    logic signed [66:0] acc_sum;
    logic signed [66:0] shifted;
    logic [35:0]        hi_bits;

    assign prod    = $signed({{32{a[32]}}, a}) * $signed({{33{b[31]}}, b});
    // Result includes the product of the current cycle so the last term needs no extra cycle
    assign acc_sum = acc_q + $signed({{2{prod[64]}}, prod});
    assign shifted = acc_sum >>> FRAC;
    assign hi_bits = shifted[66:31];

    // Saturate when bits above int32 are not a pure sign extension
    always_comb begin
        sat    = !((&hi_bits) || !(|hi_bits));
        result = shifted[31:0];
        if (sat) begin
            result = shifted[66] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
        end
    end

    // Accumulator next state: clear wins over accumulate
    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = acc_sum;
        end
    end

    // Accumulator register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/world_view_sequencer.sv
// Per-frame world-to-camera vertex transform: read, translate, project on i/j/k, write back.
module world_view_sequencer
    import world_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [TRI_AW:0]   num_tris,
    input  logic [95:0]       cam_i,
    input  logic [95:0]       cam_j,
    input  logic [95:0]       cam_k,
    input  logic [95:0]       cam_pos,
    output logic              tri_rd_en,
    output logic [TRI_AW+1:0] tri_rd_addr,
    input  logic [95:0]       tri_rd_data,
    output logic              cam_wr_en,
    output logic [TRI_AW+1:0] cam_wr_addr,
    output logic [95:0]       cam_wr_data,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    localparam logic [TRI_AW:0] MaxTris = (TRI_AW + 1)'(MAX_TRIANGLES);
    localparam logic [TRI_AW:0] OneTri  = (TRI_AW + 1)'(1);

    seq_state_e        state_q, state_d;
    logic [TRI_AW-1:0] tri_q, tri_d;
    logic [1:0]        vtx_q, vtx_d;
    logic [1:0]        axis_q, axis_d;
    logic [1:0]        comp_q, comp_d;
    logic              ovf_q, ovf_d;
    logic [TRI_AW:0]   num_q;
    logic [TRI_AW:0]   num_clamped;
    vec3               basis_i_q, basis_j_q, basis_k_q, pos_q, res_q;
    vec3               basis_sel;
    logic [2:0][32:0]  d_q;
    logic [2:0][32:0]  diff;
    logic              start_acc;
    logic              capture;
    logic              last_vtx;
    logic              mac_clr, mac_en, mac_sat;
    logic signed [31:0] mac_result;

    assign num_clamped = (num_tris > MaxTris) ? MaxTris : num_tris;
    assign last_vtx    = (vtx_q == 2'd2) && (({1'b0, tri_q} + OneTri) == num_q);

    // Translate the fetched world vertex by the snapshotted camera position, 33-bit signed
    always_comb begin
        diff = '0;
        for (int c = 0; c < 3; c++) begin
            diff[c] = {tri_rd_data[c*32+31], tri_rd_data[c*32 +: 32]} - {pos_q[c][31], pos_q[c]};
        end
    end

    // Pick the basis vector of the axis currently being accumulated
    always_comb begin
        basis_sel = basis_i_q;
        case (axis_q)
            2'd1:    basis_sel = basis_j_q;
            2'd2:    basis_sel = basis_k_q;
            default: basis_sel = basis_i_q;
        endcase
    end

    dot3_mac u_mac (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (mac_clr),
        .en      (mac_en),
        .a       (d_q[comp_q]),
        .b       (basis_sel[comp_q]),
        .result  (mac_result),
        .sat     (mac_sat)
    );

    // Sequencer next-state and strobes
    always_comb begin
        state_d   = state_q;
        tri_d     = tri_q;
        vtx_d     = vtx_q;
        axis_d    = axis_q;
        comp_d    = comp_q;
        ovf_d     = ovf_q;
        start_acc = 1'b0;
        capture   = 1'b0;
        mac_clr   = 1'b0;
        mac_en    = 1'b0;
        tri_rd_en = 1'b0;
        cam_wr_en = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    start_acc = 1'b1;
                    ovf_d     = 1'b0;
                    tri_d     = '0;
                    vtx_d     = '0;
                    state_d   = (num_clamped == '0) ? StDone : StRead;
                end
            end
            StRead: begin
                busy      = 1'b1;
                tri_rd_en = 1'b1;
                state_d   = StLatch;
            end
            StLatch: begin
                busy    = 1'b1;
                mac_clr = 1'b1;
                axis_d  = '0;
                comp_d  = '0;
                state_d = StMac;
            end
            StMac: begin
                busy   = 1'b1;
                mac_en = 1'b1;
                if (comp_q == 2'd2) begin
                    capture = 1'b1;
                    mac_clr = 1'b1;
                    comp_d  = '0;
                    if (mac_sat) begin
                        ovf_d = 1'b1;
                    end
                    if (axis_q == 2'd2) begin
                        state_d = StWrite;
                    end else begin
                        axis_d = axis_q + 2'd1;
                    end
                end else begin
                    comp_d = comp_q + 2'd1;
                end
            end
            StWrite: begin
                busy      = 1'b1;
                cam_wr_en = 1'b1;
                if (last_vtx) begin
                    state_d = StDone;
                end else begin
                    state_d = StRead;
                    if (vtx_q == 2'd2) begin
                        vtx_d = '0;
                        tri_d = tri_q + TRI_AW'(1);
                    end else begin
                        vtx_d = vtx_q + 2'd1;
                    end
                end
            end
            StDone: begin
                done    = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign tri_rd_addr = tri_rd_en ? {tri_q, vtx_q} : '0;
    assign cam_wr_addr = cam_wr_en ? {tri_q, vtx_q} : '0;
    assign cam_wr_data = cam_wr_en ? res_q : '0;
    assign ovf         = ovf_q;

    // Control state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            tri_q   <= '0;
            vtx_q   <= '0;
            axis_q  <= '0;
            comp_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            tri_q   <= tri_d;
            vtx_q   <= vtx_d;
            axis_q  <= axis_d;
            comp_q  <= comp_d;
            ovf_q   <= ovf_d;
        end
    end

    // Frame snapshot so mid-frame input changes cannot disturb the transform
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            basis_i_q <= '0;
            basis_j_q <= '0;
            basis_k_q <= '0;
            pos_q     <= '0;
            num_q     <= '0;
        end else if (start_acc) begin
            basis_i_q <= cam_i;
            basis_j_q <= cam_j;
            basis_k_q <= cam_k;
            pos_q     <= cam_pos;
            num_q     <= num_clamped;
        end
    end

    // Vertex datapath: translated vertex and per-axis results (axis i/j/k -> X/Y/Z)
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            d_q   <= '0;
            res_q <= '0;
        end else begin
            if (state_q == StLatch) begin
                d_q <= diff;
            end
            if (capture) begin
                res_q[axis_q] <= mac_result;
            end
        end
    end

endmodule

// File: tb/tb_world_view_sequencer.sv
// Scoreboard bench for world_view_sequencer: expected writes queued at frame start, popped on writes.
module tb_world_view_sequencer;
    import world_pkg::*;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              start;
    logic [TRI_AW:0]   num_tris;
    logic [95:0]       cam_i, cam_j, cam_k, cam_pos;
    logic              tri_rd_en;
    logic [TRI_AW+1:0] tri_rd_addr;
    logic [95:0]       tri_rd_data;
    logic              cam_wr_en;
    logic [TRI_AW+1:0] cam_wr_addr;
    logic [95:0]       cam_wr_data;
    logic              busy, done, ovf;

    typedef struct packed {
        logic [7:0]  addr;
        logic [95:0] data;
    } wr_t;

    logic [95:0] mem [0:255];
    wr_t         sb[$];
    wr_t         mon_e;
    int          n_checks = 0;
    int          n_fail   = 0;
    int          wr_cnt   = 0;
    int          rd_cnt   = 0;
    bit          exp_ovf;

    world_view_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .num_tris    (num_tris),
        .cam_i       (cam_i),
        .cam_j       (cam_j),
        .cam_k       (cam_k),
        .cam_pos     (cam_pos),
        .tri_rd_en   (tri_rd_en),
        .tri_rd_addr (tri_rd_addr),
        .tri_rd_data (tri_rd_data),
        .cam_wr_en   (cam_wr_en),
        .cam_wr_addr (cam_wr_addr),
        .cam_wr_data (cam_wr_data),
        .busy        (busy),
        .done        (done),
        .ovf         (ovf)
    );

    always #5 clk = ~clk;

    // Triangle memory: one-cycle read latency
    always @(posedge clk) begin
        if (tri_rd_en) tri_rd_data <= mem[tri_rd_addr];
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Write monitor: pops the scoreboard on every camera-space write
    always @(negedge clk) begin
        if (tri_rd_en) begin
            rd_cnt++;
            check("rd_slot3", {7'd0, tri_rd_addr[1:0] == 2'd3}, 0);
        end
        if (cam_wr_en) begin
            wr_cnt++;
            if (sb.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                check("wr_addr", cam_wr_addr, mon_e.addr);
                check("wr_data", cam_wr_data, mon_e.data);
            end
        end
    end

    function automatic logic [95:0] vec(input logic [31:0] x, input logic [31:0] y,
                                        input logic [31:0] z);
        return {z, y, x};
    endfunction

    function automatic int rnd(input int m);
        return int'($urandom_range(0, 2 * m)) - m;
    endfunction

    // Reference dot product: full-precision sum, >>> 10, clamp to int32
    function automatic logic [31:0] model_axis(input logic [95:0] vx, input logic [95:0] pos,
                                               input logic [95:0] bas, output bit s);
        logic signed [66:0] acc, vv, pp, bb, sh;
        acc = '0;
        for (int c = 0; c < 3; c++) begin
            vv  = $signed({{35{vx[c*32+31]}}, vx[c*32 +: 32]});
            pp  = $signed({{35{pos[c*32+31]}}, pos[c*32 +: 32]});
            bb  = $signed({{35{bas[c*32+31]}}, bas[c*32 +: 32]});
            acc = acc + (vv - pp) * bb;
        end
        sh = acc >>> 10;
        s  = 1'b1;
        if (sh > $signed(67'h0_7FFF_FFFF)) return 32'h7FFF_FFFF;
        if (sh < -$signed(67'h0_8000_0000)) return 32'h8000_0000;
        s = 1'b0;
        return sh[31:0];
    endfunction

    task automatic push_hand(input logic [7:0] a, input logic [95:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic push_vertex(input int t, input int v);
        logic [7:0]  a;
        logic [31:0] rx, ry, rz;
        bit          s0, s1, s2;
        a  = 8'(t * 4 + v);
        rx = model_axis(mem[a], cam_pos, cam_i, s0);
        ry = model_axis(mem[a], cam_pos, cam_j, s1);
        rz = model_axis(mem[a], cam_pos, cam_k, s2);
        exp_ovf = exp_ovf | s0 | s1 | s2;
        push_hand(a, vec(rx, ry, rz));
    endtask

    task automatic push_model(input int n);
        exp_ovf = 1'b0;
        for (int t = 0; t < n; t++)
            for (int v = 0; v < 3; v++) push_vertex(t, v);
    endtask

    task automatic random_camera();
        cam_i   = vec(rnd(1024), rnd(1024), rnd(1024));
        cam_j   = vec(rnd(1024), rnd(1024), rnd(1024));
        cam_k   = vec(rnd(1024), rnd(1024), rnd(1024));
        cam_pos = vec(rnd(50000), rnd(50000), rnd(50000));
    endtask

    // Runs one frame from a start pulse; checks busy/done timing, write count and ovf
    task automatic run_frame(input logic [TRI_AW:0] n_in, input int n_eff, input bit mid);
        int k, busy_cnt, done_at, wr0, rd0;
        num_tris = n_in;
        @(negedge clk);
        start = 1'b1;
        wr0   = wr_cnt;
        rd0   = rd_cnt;
        @(negedge clk);
        start    = 1'b0;
        k        = 1;
        busy_cnt = 0;
        done_at  = -1;
        while (k <= 36 * n_eff + 5 && done_at < 0) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_at = k;
                check("busy_in_done", busy, 0);
            end
            if (mid && k == 5) begin
                cam_pos = ~cam_pos;
                cam_i   = vec(32'd7, 32'd7, 32'd7);
                start   = 1'b1;
            end
            if (mid && k == 6) start = 1'b0;
            @(negedge clk);
            k++;
        end
        check("done_cycle", done_at, 36 * n_eff + 1);
        check("busy_cycles", busy_cnt, 36 * n_eff);
        check("idle_after", {busy, done}, 0);
        check("ovf", ovf, exp_ovf);
        check("wr_count", wr_cnt - wr0, 3 * n_eff);
        check("rd_count", rd_cnt - rd0, 3 * n_eff);
        check("sb_empty", sb.size(), 0);
        @(negedge clk);
        check("no_restart", busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int wr0;
        reset_n  = 1'b0;
        start    = 1'b0;
        num_tris = '0;
        cam_i    = '0;
        cam_j    = '0;
        cam_k    = '0;
        cam_pos  = '0;
        for (int i = 0; i < 256; i++) mem[i] = vec(rnd(100000), rnd(100000), rnd(100000));
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ovf", ovf, 0);
        check("rst_rd_en", tri_rd_en, 0);
        check("rst_wr_en", cam_wr_en, 0);
        check("rst_wr_data", cam_wr_data, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Identity basis, camera at origin
        cam_i   = vec(32'd1024, 32'd0, 32'd0);
        cam_j   = vec(32'd0, 32'd1024, 32'd0);
        cam_k   = vec(32'd0, 32'd0, 32'd1024);
        cam_pos = '0;
        mem[0]  = vec(32'd100, 32'd200, 32'd300);
        exp_ovf = 1'b0;
        push_hand(8'd0, vec(32'd100, 32'd200, 32'd300));
        push_vertex(0, 1);
        push_vertex(0, 2);
        run_frame(7'd1, 1, 1'b0);

        // Permuted basis with translation
        cam_i   = vec(32'd1024, 32'd0, 32'd0);
        cam_j   = vec(32'd0, 32'd0, 32'd1024);
        cam_k   = vec(32'd0, 32'd1024, 32'd0);
        cam_pos = vec(32'd150, 32'd0, 32'd150);
        mem[0]  = vec(32'd200, 32'd50, 32'd400);
        exp_ovf = 1'b0;
        push_hand(8'd0, vec(32'd50, 32'd250, 32'd50));
        push_vertex(0, 1);
        push_vertex(0, 2);
        run_frame(7'd1, 1, 1'b0);

        // Two triangles, random camera
        random_camera();
        push_model(2);
        run_frame(7'd2, 2, 1'b0);

        // Empty frame
        exp_ovf = 1'b0;
        run_frame(7'd0, 0, 1'b0);

        // Positive saturation on X
        cam_i   = vec(32'd1024, 32'd0, 32'd0);
        cam_j   = vec(32'd0, 32'd1024, 32'd0);
        cam_k   = vec(32'd0, 32'd0, 32'd1024);
        cam_pos = vec(32'h8000_0000, 32'd0, 32'd0);
        mem[0]  = vec(32'h7FFF_FFFF, 32'd10, 32'd20);
        mem[1]  = '0;
        mem[2]  = '0;
        exp_ovf = 1'b1;
        push_hand(8'd0, vec(32'h7FFF_FFFF, 32'd10, 32'd20));
        push_vertex(0, 1);
        push_vertex(0, 2);
        run_frame(7'd1, 1, 1'b0);
        repeat (5) @(negedge clk);
        check("ovf_held", ovf, 1);
        exp_ovf = 1'b0;
        run_frame(7'd0, 0, 1'b0);

        // Mid-frame input changes and an extra start must be ignored
        for (int i = 0; i < 8; i++) mem[i] = vec(rnd(100000), rnd(100000), rnd(100000));
        random_camera();
        push_model(2);
        run_frame(7'd2, 2, 1'b1);

        // Oversized triangle count clamps to capacity
        random_camera();
        for (int i = 0; i < 256; i++) mem[i] = vec(rnd(100000), rnd(100000), rnd(100000));
        push_model(64);
        run_frame(7'd100, 64, 1'b0);

        // Reset during MAC abandons the vertex
        random_camera();
        num_tris = 7'd1;
        wr0      = wr_cnt;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        check("mac_busy", busy, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_wr_en", cam_wr_en, 0);
        check("abort_rd_en", tri_rd_en, 0);
        check("abort_wr_data", cam_wr_data, 0);
        check("abort_done", done, 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check("abort_no_write", wr_cnt - wr0, 0);
        check("abort_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
